// File: rtl/flow_sequencer_if.sv
// Instruction/flag inputs and datapath control outputs of the flow sequencer.
// master = sequencer side, slave = memory/datapath side.
interface flow_sequencer_if;
  logic [15:0] current_instruction;
  logic [15:0] zeroflag;
  logic        step_mode;
  logic        step;
  logic        program_counter_increment;
  logic [3:0]  alu_op;
  logic [15:0] alu_a_altern;
  logic [15:0] alu_b_altern;
  logic [3:0]  alu_a_select;
  logic [3:0]  alu_b_select;
  logic        alu_a_source;
  logic        alu_b_source;
  logic [3:0]  alu_out_select;
  logic [1:0]  alu_load_src;
  logic        alu_store_to_mem;
  logic        alu_store_to_stk;
  logic [3:0]  vga_color_select;
  logic [3:0]  vga_coord_select;
  logic        vga_write;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    input  current_instruction, zeroflag, step_mode, step,
    output program_counter_increment, alu_op, alu_a_altern, alu_b_altern,
           alu_a_select, alu_b_select, alu_a_source, alu_b_source,
           alu_out_select, alu_load_src, alu_store_to_mem, alu_store_to_stk,
           vga_color_select, vga_coord_select, vga_write, halted, illegal, state
  );

  modport slave (
    output current_instruction, zeroflag, step_mode, step,
    input  program_counter_increment, alu_op, alu_a_altern, alu_b_altern,
           alu_a_select, alu_b_select, alu_a_source, alu_b_source,
           alu_out_select, alu_load_src, alu_store_to_mem, alu_store_to_stk,
           vga_color_select, vga_coord_select, vga_write, halted, illegal, state
  );
endinterface

// File: rtl/flow_sequencer.sv
// Multi-cycle fetch/decode/execute controller: 3 cycles per instruction, 4 for imm/load forms.
// No backpressure; step_mode holds the sequencer in FETCH until a step pulse.
module flow_sequencer (
  input  logic             clock,
  input  logic             resetn,
  flow_sequencer_if.master bus
);
  localparam logic [3:0] ALU_PASS_B = 4'h0;

  localparam logic [3:0] C_NOP  = 4'h0;
  localparam logic [3:0] C_ALU  = 4'h1;
  localparam logic [3:0] C_ALUI = 4'h2;
  localparam logic [3:0] C_LD   = 4'h3;
  localparam logic [3:0] C_ST   = 4'h4;
  localparam logic [3:0] C_LDS  = 4'h5;
  localparam logic [3:0] C_STS  = 4'h6;
  localparam logic [3:0] C_JZ   = 4'h7;
  localparam logic [3:0] C_JMP  = 4'h8;
  localparam logic [3:0] C_DRAW = 4'h9;
  localparam logic [3:0] C_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_IMM    = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] imm_q;
  logic [3:0]  cls, fn, rd, rb;

  assign cls = ir_q[15:12];
  assign fn  = ir_q[11:8];
  assign rd  = ir_q[7:4];
  assign rb  = ir_q[3:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && state_d == S_DECODE)
        ir_q <= bus.current_instruction;
      // r0 already points past the opcode, so memory now shows the immediate word
      if (state_q == S_IMM)
        imm_q <= bus.current_instruction;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (!(bus.step_mode && !bus.step)) state_d = S_DECODE;
      S_DECODE: begin
        if (cls == C_ALUI || cls == C_JMP) state_d = S_IMM;
        else if (cls == C_HALT)            state_d = S_HALT;
        else                               state_d = S_EXEC;
      end
      S_IMM:    state_d = S_EXEC;
      S_EXEC:   state_d = (cls == C_LD || cls == C_LDS) ? S_WAIT : S_FETCH;
      S_WAIT:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.alu_a_altern = 16'h0000;
  assign bus.alu_a_source = 1'b0;
  assign bus.halted       = (state_q == S_HALT);

  always_comb begin
    bus.program_counter_increment = 1'b0;
    bus.alu_op                    = ALU_PASS_B;
    bus.alu_b_altern              = 16'h0000;
    bus.alu_a_select              = 4'h0;
    bus.alu_b_select              = 4'h0;
    bus.alu_b_source              = 1'b0;
    bus.alu_out_select            = 4'h0;
    bus.alu_load_src              = 2'b00;
    bus.alu_store_to_mem          = 1'b0;
    bus.alu_store_to_stk          = 1'b0;
    bus.vga_color_select          = 4'h0;
    bus.vga_coord_select          = 4'h0;
    bus.vga_write                 = 1'b0;
    bus.illegal                   = 1'b0;
    case (state_q)
      S_DECODE: bus.program_counter_increment = 1'b1;
      S_EXEC: begin
        case (cls)
          C_NOP, C_HALT: ;
          C_ALU, C_ALUI: begin
            bus.alu_a_select   = rd;
            bus.alu_b_select   = rb;
            bus.alu_op         = fn;
            bus.alu_out_select = rd;
            bus.alu_load_src   = 2'b01;
            if (cls == C_ALUI) begin
              bus.alu_b_source              = 1'b1;
              bus.alu_b_altern              = imm_q;
              bus.program_counter_increment = 1'b1;
            end
          end
          C_LD, C_LDS: begin
            bus.alu_b_select   = rb;
            bus.alu_out_select = rd;
          end
          C_ST, C_STS: begin
            bus.alu_b_select     = rb;
            bus.alu_out_select   = rd;
            bus.alu_store_to_mem = (cls == C_ST);
            bus.alu_store_to_stk = (cls == C_STS);
          end
          // zeroflag is read live here; the DECODE increment only disturbs flag 0
          C_JZ: begin
            if (bus.zeroflag[rd]) begin
              bus.alu_b_select = rb;
              bus.alu_load_src = 2'b01;
            end
          end
          C_JMP: begin
            bus.alu_b_source = 1'b1;
            bus.alu_b_altern = imm_q;
            bus.alu_load_src = 2'b01;
          end
          C_DRAW: begin
            bus.vga_color_select = rd;
            bus.vga_coord_select = rb;
            bus.vga_write        = 1'b1;
          end
          default: bus.illegal = 1'b1;
        endcase
      end
      S_WAIT: begin
        bus.alu_b_select   = rb;
        bus.alu_out_select = rd;
        bus.alu_load_src   = (cls == C_LDS) ? 2'b11 : 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_flow_sequencer.sv
// Directed table-driven bench for flow_sequencer plus hand sequences for halt, step and reset.
module tb_flow_sequencer;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  flow_sequencer_if bus ();

  flow_sequencer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clock = ~clock;

  // Any control other than pc_increment away from its default.
  logic ctl_busy;
  assign ctl_busy = |{bus.alu_op, bus.alu_a_altern, bus.alu_b_altern, bus.alu_a_select,
                      bus.alu_b_select, bus.alu_a_source, bus.alu_b_source, bus.alu_out_select,
                      bus.alu_load_src, bus.alu_store_to_mem, bus.alu_store_to_stk,
                      bus.vga_color_select, bus.vga_coord_select, bus.vga_write};

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] imm;
    logic [15:0] zf;
    logic        two;
    logic        wt;
    logic [3:0]  op;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        b_src;
    logic [15:0] b_alt;
    logic [3:0]  out_sel;
    logic [1:0]  ld;
    logic [1:0]  wt_ld;
    logic        pc;
    logic        st_mem;
    logic        st_stk;
    logic [3:0]  col;
    logic [3:0]  crd;
    logic        vw;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_vec(input vec_t v);
    bus.current_instruction = v.ir;
    bus.zeroflag            = v.zf;
    chk("fetch_state", bus.state, 0);
    tick();
    chk("decode_state", bus.state, 1);
    chk("decode_pcinc", bus.program_counter_increment, 1);
    chk("decode_idle", {ctl_busy, bus.illegal, bus.halted}, 0);
    bus.current_instruction = v.imm;
    if (v.two) begin
      tick();
      chk("imm_state", bus.state, 2);
      chk("imm_idle", {ctl_busy, bus.program_counter_increment}, 0);
    end
    tick();
    bus.current_instruction = 16'h0000;
    chk("exec_state", bus.state, 3);
    chk("exec_op", bus.alu_op, v.op);
    chk("exec_asel", bus.alu_a_select, v.a_sel);
    chk("exec_bsel", bus.alu_b_select, v.b_sel);
    chk("exec_bsrc", bus.alu_b_source, v.b_src);
    chk("exec_balt", bus.alu_b_altern, v.b_alt);
    chk("exec_outsel", bus.alu_out_select, v.out_sel);
    chk("exec_ldsrc", bus.alu_load_src, v.ld);
    chk("exec_pcinc", bus.program_counter_increment, v.pc);
    chk("exec_store", {bus.alu_store_to_mem, bus.alu_store_to_stk}, {v.st_mem, v.st_stk});
    chk("exec_vga", {bus.vga_color_select, bus.vga_coord_select, bus.vga_write},
        {v.col, v.crd, v.vw});
    chk("exec_illegal", bus.illegal, v.ill);
    chk("exec_a_fixed", {bus.alu_a_source, bus.alu_a_altern}, 0);
    if (v.wt) begin
      tick();
      chk("wait_state", bus.state, 4);
      chk("wait_ldsrc", bus.alu_load_src, v.wt_ld);
      chk("wait_sel", {bus.alu_b_select, bus.alu_out_select}, {v.b_sel, v.out_sel});
    end
    tick();
    chk("back_fetch", bus.state, 0);
    chk("fetch_idle", {ctl_busy, bus.program_counter_increment, bus.illegal}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{ir:16'h1A12, op:4'hA, a_sel:4'h1, b_sel:4'h2, out_sel:4'h1, ld:2'b01, default:'0};
    vecs[1]  = '{ir:16'h2312, imm:16'h00FF, two:1'b1, op:4'h3, a_sel:4'h1, b_sel:4'h2, b_src:1'b1,
                 b_alt:16'h00FF, out_sel:4'h1, ld:2'b01, pc:1'b1, default:'0};
    vecs[2]  = '{ir:16'h3045, wt:1'b1, b_sel:4'h5, out_sel:4'h4, wt_ld:2'b10, default:'0};
    vecs[3]  = '{ir:16'h5045, wt:1'b1, b_sel:4'h5, out_sel:4'h4, wt_ld:2'b11, default:'0};
    vecs[4]  = '{ir:16'h4021, b_sel:4'h1, out_sel:4'h2, st_mem:1'b1, default:'0};
    vecs[5]  = '{ir:16'h6021, b_sel:4'h1, out_sel:4'h2, st_stk:1'b1, default:'0};
    vecs[6]  = '{ir:16'h7036, zf:16'h0008, b_sel:4'h6, ld:2'b01, default:'0};
    vecs[7]  = '{ir:16'h7036, zf:16'hFFF7, default:'0};
    vecs[8]  = '{ir:16'h8000, imm:16'h1234, two:1'b1, b_src:1'b1, b_alt:16'h1234, ld:2'b01,
                 default:'0};
    vecs[9]  = '{ir:16'h9057, col:4'h5, crd:4'h7, vw:1'b1, default:'0};
    vecs[10] = '{ir:16'hB000, ill:1'b1, default:'0};
    vecs[11] = '{ir:16'h0000, default:'0};
    vecs[12] = '{ir:16'h10F0, a_sel:4'hF, out_sel:4'hF, ld:2'b01, default:'0};

    bus.current_instruction = 16'h0000;
    bus.zeroflag            = 16'h0000;
    bus.step_mode           = 1'b0;
    bus.step                = 1'b0;
    #2;
    chk("reset_state", bus.state, 0);
    chk("reset_ctl", {ctl_busy, bus.program_counter_increment}, 0);
    chk("reset_flags", {bus.halted, bus.illegal}, 0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Halt: sticky, controls idle, ignores step and instruction changes.
    bus.current_instruction = 16'hF000;
    tick();
    chk("halt_decode", bus.state, 1);
    tick();
    chk("halt_enter", {bus.state, bus.halted}, {3'd5, 1'b1});
    for (int c = 0; c < 100; c++) begin
      bus.current_instruction = 16'h1A12 + 16'(c);
      bus.step = c[0];
      tick();
      chk("halt_hold", {bus.state, bus.halted, ctl_busy, bus.program_counter_increment,
                        bus.illegal}, {3'd5, 1'b1, 3'b000});
    end
    bus.step = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("halt_reset", {bus.state, bus.halted}, 0);
    @(negedge clock);
    resetn = 1'b1;
    run_vec(vecs[11]);

    // Step mode: hold in FETCH, one pulse admits one instruction.
    bus.step_mode = 1'b1;
    bus.current_instruction = 16'h1A12;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("step_hold", bus.state, 0);
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("step_decode", bus.state, 1);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("step_exec", {bus.state, bus.alu_op}, {3'd3, 4'hA});
    tick();
    chk("step_fetch", bus.state, 0);
    tick();
    chk("step_ignored", bus.state, 0);
    bus.step_mode = 1'b0;
    tick();
    chk("step_off", bus.state, 1);
    tick();
    tick();

    // Asynchronous reset in the middle of a load's WAIT cycle.
    bus.current_instruction = 16'h3045;
    chk("ld_fetch", bus.state, 0);
    tick();
    tick();
    tick();
    chk("ld_wait", {bus.state, bus.alu_load_src}, {3'd4, 2'b10});
    #1 resetn = 1'b0;
    #1;
    chk("wait_reset", {bus.state, bus.alu_load_src, bus.alu_out_select}, 0);
    @(negedge clock);
    resetn = 1'b1;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
